// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN coefficient path.
package cnn_pkg;

    localparam int unsigned CoefWidth = 16;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StDrain
    } load_state_e;

endpackage

// File: rtl/coef_bank.sv
// Double-buffered coefficient store: a shadow bank is filled word by word, and
// a commit copies it, including a same-cycle write, into the active bank.
module coef_bank
    import cnn_pkg::*;
#(
    parameter int unsigned WIDTH = CoefWidth,
    parameter int unsigned NCOEF = 40,
    localparam int unsigned IdxW = $clog2(NCOEF)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   we_i,
    input  logic [IdxW-1:0]        waddr_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   commit_i,
    output logic [NCOEF*WIDTH-1:0] coef_o
);

    logic [WIDTH-1:0] shadow_q [NCOEF];
    logic [WIDTH-1:0] shadow_d [NCOEF];
    logic [WIDTH-1:0] active_q [NCOEF];
    logic [WIDTH-1:0] active_d [NCOEF];

    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        if (we_i) begin
            shadow_d[waddr_i] = wdata_i;
        end
        // Commit takes the merged shadow so the final word lands in the same edge.
        if (commit_i) begin
            active_d = shadow_d;
        end
    end

    // Reset is synchronous.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            shadow_q <= '{default: '0};
            active_q <= '{default: '0};
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    for (genvar i = 0; i < NCOEF; i++) begin : g_flat
        assign coef_o[i*WIDTH +: WIDTH] = active_q[i];
    end

endmodule

// File: rtl/coef_loader.sv
// Loads one frame of NCOEF coefficient words from a valid/ready stream and
// publishes it atomically; malformed frames set a sticky error and are dropped.
module coef_loader
    import cnn_pkg::*;
#(
    parameter int unsigned WIDTH = CoefWidth,
    parameter int unsigned NCOEF = 40
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   start,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [WIDTH-1:0]       s_data,
    input  logic                   s_last,
    output logic [NCOEF*WIDTH-1:0] coef_o,
    output logic                   coef_valid,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int unsigned IdxW = $clog2(NCOEF);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NCOEF - 1);

    load_state_e     state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            err_q, err_d;
    logic            done_q, done_d;
    logic            valid_q, valid_d;
    logic            bank_we, bank_commit;
    logic            hs;

    assign s_ready = (state_q != StIdle);
    assign busy    = s_ready;
    assign hs      = s_valid && s_ready;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        err_d       = err_q;
        done_d      = 1'b0;
        valid_d     = valid_q;
        bank_we     = 1'b0;
        bank_commit = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoad;
                    idx_d   = '0;
                    err_d   = 1'b0;
                end
            end
            StLoad: begin
                if (hs) begin
                    if (idx_q == LastIdx) begin
                        if (s_last) begin
                            bank_we     = 1'b1;
                            bank_commit = 1'b1;
                            done_d      = 1'b1;
                            valid_d     = 1'b1;
                            state_d     = StIdle;
                        end else begin
                            err_d   = 1'b1;
                            state_d = StDrain;
                        end
                    end else if (s_last) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end else begin
                        bank_we = 1'b1;
                        idx_d   = idx_q + IdxW'(1);
                    end
                end
            end
            StDrain: begin
                if (hs && s_last) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= StIdle;
            idx_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            done_q  <= done_d;
            valid_q <= valid_d;
        end
    end

    assign done       = done_q;
    assign err        = err_q;
    assign coef_valid = valid_q;

    coef_bank #(
        .WIDTH(WIDTH),
        .NCOEF(NCOEF)
    ) u_bank (
        .clk_i   (clk),
        .rst_ni  (resetn),
        .we_i    (bank_we),
        .waddr_i (idx_q),
        .wdata_i (s_data),
        .commit_i(bank_commit),
        .coef_o  (coef_o)
    );

endmodule

// File: tb/tb_coef_loader.sv
// Bench for coef_loader: directed frames plus randomized traffic, checked every
// cycle against a queue-based frame model.
module tb_coef_loader;

    localparam int unsigned W = 8;
    localparam int unsigned N = 4;

    logic           clk = 1'b0;
    logic           resetn;
    logic           start;
    logic           s_valid;
    logic           s_ready;
    logic [W-1:0]   s_data;
    logic           s_last;
    logic [N*W-1:0] coef_o;
    logic           coef_valid;
    logic           busy;
    logic           done;
    logic           err;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    coef_loader #(
        .WIDTH(W),
        .NCOEF(N)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .coef_o    (coef_o),
        .coef_valid(coef_valid),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    // Frame model: collects accepted words in a queue and judges the frame by its length.
    bit         m_active, m_drain, m_done, m_valid, m_err;
    logic [7:0] words[$];
    logic [31:0] m_coef;

    always @(posedge clk) begin
        m_done = 1'b0;
        if (!resetn) begin
            m_active = 0; m_drain = 0; m_valid = 0; m_err = 0; m_coef = '0;
            words.delete();
        end else if (!m_active) begin
            if (start) begin
                m_active = 1; m_drain = 0; m_err = 0;
                words.delete();
            end
        end else if (s_valid) begin
            if (m_drain) begin
                if (s_last) m_active = 0;
            end else begin
                words.push_back(s_data);
                if (words.size() == N) begin
                    if (s_last) begin
                        for (int i = 0; i < N; i++) m_coef[i*8 +: 8] = words[i];
                        m_valid = 1; m_done = 1; m_active = 0;
                    end else begin
                        m_err = 1; m_drain = 1;
                    end
                end else if (s_last) begin
                    m_err = 1; m_active = 0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (chk_en) begin
            chk("s_ready", {31'b0, s_ready}, {31'b0, m_active});
            chk("busy", {31'b0, busy}, {31'b0, m_active});
            chk("done", {31'b0, done}, {31'b0, m_done});
            chk("coef_valid", {31'b0, coef_valid}, {31'b0, m_valid});
            chk("err", {31'b0, err}, {31'b0, m_err});
            chk("coef_o", coef_o, m_coef);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] d, input bit last, input int bubbles,
                             input bit with_start);
        for (int b = 0; b < bubbles; b++) tick();
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        start   = with_start;
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
        start   = 1'b0;
    endtask

    task automatic pulse_reset();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int base;
        int len;
        resetn = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        chk_en = 1'b1;
        chk("reset_coef_o", coef_o, 32'h0);
        chk("reset_ready", {31'b0, s_ready}, 32'h0);
        tick();

        // Back-to-back good frame.
        do_start();
        send_word(8'h01, 0, 0, 0);
        send_word(8'h02, 0, 0, 0);
        send_word(8'h03, 0, 0, 0);
        send_word(8'h84, 1, 0, 0);
        chk("b2b_done", {31'b0, done}, 32'h1);
        chk("b2b_coef", coef_o, 32'h84030201);
        chk("model_coef", m_coef, 32'h84030201);
        chk("b2b_valid", {31'b0, coef_valid}, 32'h1);
        chk("b2b_err", {31'b0, err}, 32'h0);
        tick();
        chk("b2b_done_once", done_cnt, 32'd1);

        // Same frame with three bubble cycles before each word.
        base = done_cnt;
        do_start();
        send_word(8'h01, 0, 3, 0);
        send_word(8'h02, 0, 3, 0);
        send_word(8'h03, 0, 3, 0);
        send_word(8'h84, 1, 3, 0);
        tick(); tick();
        chk("bubble_coef", coef_o, 32'h84030201);
        chk("bubble_done_cnt", done_cnt - base, 32'd1);

        // Short frame.
        base = done_cnt;
        do_start();
        send_word(8'h11, 0, 0, 0);
        send_word(8'h22, 1, 0, 0);
        tick();
        chk("short_err", {31'b0, err}, 32'h1);
        chk("short_coef", coef_o, 32'h84030201);
        chk("short_idle", {31'b0, busy}, 32'h0);
        chk("short_no_done", done_cnt - base, 32'd0);

        // Long frame: error after 4th word, drain the rest.
        do_start();
        for (int i = 0; i < 4; i++) send_word(8'(8'h50 + i), 0, 0, 0);
        chk("long_err", {31'b0, err}, 32'h1);
        chk("long_drain_busy", {31'b0, busy}, 32'h1);
        send_word(8'h55, 0, 0, 0);
        send_word(8'h56, 1, 0, 0);
        chk("long_busy_low", {31'b0, busy}, 32'h0);
        chk("long_coef", coef_o, 32'h84030201);
        chk("long_no_done", done_cnt - base, 32'd0);

        // Reset mid-frame, then words without start are refused.
        do_start();
        send_word(8'h77, 0, 0, 0);
        send_word(8'h78, 0, 0, 0);
        pulse_reset();
        chk("rst_coef", coef_o, 32'h0);
        chk("rst_valid", {31'b0, coef_valid}, 32'h0);
        chk("rst_err", {31'b0, err}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        s_valid = 1'b1; s_data = 8'h79;
        tick();
        chk("rst_no_ready", {31'b0, s_ready}, 32'h0);
        s_valid = 1'b0;
        tick();

        // Start pulsed mid-load is ignored.
        do_start();
        send_word(8'hA1, 0, 0, 0);
        send_word(8'hB2, 0, 0, 1);
        send_word(8'hC3, 0, 1, 1);
        send_word(8'hD4, 1, 0, 0);
        chk("restart_done", {31'b0, done}, 32'h1);
        chk("restart_coef", coef_o, 32'hD4C3B2A1);
        tick();

        // Randomized traffic.
        for (int f = 0; f < 150; f++) begin
            len = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : 4;
            if ($urandom_range(0, 9) != 0) do_start();
            for (int w = 0; w < len; w++) begin
                if ($urandom_range(0, 39) == 0) pulse_reset();
                send_word(8'($urandom_range(0, 255)), w == len - 1,
                          int'($urandom_range(0, 2)), $urandom_range(0, 7) == 0);
            end
            if ($urandom_range(0, 3) == 0) tick();
        end
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
